// File: rtl/csr_uart_pkg.sv
// Shared types and constants for the CSR-mapped UART.
// Optional feature macro: CSR_UART_OVERRUN_EN (sticky overrun flag in STATUS[2]).
package csr_uart_pkg;

  // Transmitter states
  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_START = 2'd1,
    T_DATA  = 2'd2,
    T_STOP  = 2'd3
  } tx_state_e;

  // Receiver states
  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_e;

  // Register indices within the bank (csr_a[9:2])
  localparam logic [7:0] REG_RXTX   = 8'd0;
  localparam logic [7:0] REG_STATUS = 8'd1;

  // STATUS bit positions
  localparam int STAT_RX_FULL = 0;
  localparam int STAT_TX_BUSY = 1;
  localparam int STAT_OVERRUN = 2;

endpackage

// File: rtl/csr_uart_rx.sv
// UART receiver: 2-flop synchronizer, 8N1 deframing FSM, registered byte
// output with a one-cycle valid strobe. Bytes with a bad stop bit never
// raise valid; a start bit that samples high is treated as a glitch.
// The current FSM state is exported on rx_state for observation.
module csr_uart_rx
  import csr_uart_pkg::*;
#(
  parameter logic [15:0] P_CLK_DIV = 16'd434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output rx_state_e  rx_state
);

  localparam logic [15:0] HALF_M1 = (P_CLK_DIV >> 1) - 16'd1;
  localparam logic [15:0] DIV_M1  = P_CLK_DIV - 16'd1;

  logic        sync1_q, sync2_q, prev_q;
  rx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic        valid_q, valid_d;

  // Synchronize the asynchronous line and keep one delayed copy for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Receiver FSM: state, divider, bit counter, shifter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= R_IDLE;
      cnt_q   <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      byte_q  <= 8'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic: half-bit wait to the start-bit centre, then full bits
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    case (state_q)
      R_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = R_START;
          cnt_d   = 16'd0;
        end
      end
      R_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = 16'd0;
          bit_d   = 3'd0;
          state_d = sync2_q ? R_IDLE : R_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      R_DATA: begin
        if (cnt_q == DIV_M1) begin
          cnt_d   = 16'd0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = R_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      R_STOP: begin
        if (cnt_q == DIV_M1) begin
          cnt_d   = 16'd0;
          state_d = R_IDLE;
          if (sync2_q) begin
            valid_d = 1'b1;
            byte_d  = shift_q;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  assign rx_byte  = byte_q;
  assign rx_valid = valid_q;
  assign rx_state = state_q;

endmodule

// File: rtl/csr_uart.sv
// CSR-mapped 8N1 UART: RXTX / STATUS registers, transmitter FSM, receiver
// sub-module. Optional macro CSR_UART_OVERRUN_EN adds a sticky overrun flag
// in STATUS[2], cleared by writing STATUS with bit 2 set.
module csr_uart
  import csr_uart_pkg::*;
#(
  parameter logic [3:0]  P_CSR_ADDR = 4'h0,
  parameter logic [15:0] P_CLK_DIV  = 16'd434
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        rx_irq,
  output logic        tx_irq,
  input  logic        uart_rxd,
  output logic        uart_txd
);

  localparam logic [15:0] DIV_M1 = P_CLK_DIV - 16'd1;

  // Address decode
  logic       bank_sel;
  logic [7:0] reg_idx;
  logic       wr_rxtx;
  assign bank_sel = (csr_a[13:10] == P_CSR_ADDR);
  assign reg_idx  = csr_a[9:2];
  assign wr_rxtx  = csr_we && bank_sel && (reg_idx == REG_RXTX);

  // Receiver
  logic [7:0] rx_byte;
  logic       rx_valid;
  rx_state_e  rx_state_unused;

  csr_uart_rx #(.P_CLK_DIV(P_CLK_DIV)) u_rx (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .rxd      (uart_rxd),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_state (rx_state_unused)
  );

  // Receive flags: a new byte beats a simultaneous RXTX-write clear
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_full_q, rx_full_d;

  always_comb begin
    rx_data_d = rx_data_q;
    rx_full_d = rx_full_q;
    if (wr_rxtx) rx_full_d = 1'b0;
    if (rx_valid) begin
      rx_full_d = 1'b1;
      rx_data_d = rx_byte;
    end
  end

  // Receive flag registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_data_q <= 8'd0;
      rx_full_q <= 1'b0;
    end else begin
      rx_data_q <= rx_data_d;
      rx_full_q <= rx_full_d;
    end
  end

  logic overrun;
`ifdef CSR_UART_OVERRUN_EN
  logic wr_status;
  logic overrun_q, overrun_d;
  assign wr_status = csr_we && bank_sel && (reg_idx == REG_STATUS);

  // Sticky overrun: set when a byte lands on a still-full buffer; set beats clear
  always_comb begin
    overrun_d = overrun_q;
    if (wr_status && csr_di[STAT_OVERRUN]) overrun_d = 1'b0;
    if (rx_valid && rx_full_q) overrun_d = 1'b1;
  end

  // Overrun flag register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) overrun_q <= 1'b0;
    else            overrun_q <= overrun_d;
  end
  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

  // Transmitter
  tx_state_e  tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        txd_q, txd_d;
  logic        tx_irq_q, tx_irq_d;
  logic        tx_busy;
  assign tx_busy = (tx_state_q != T_IDLE);

  // TX next-state: line level is registered so the start bit appears the cycle after the write
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_irq_d   = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        txd_d = 1'b1;
        if (wr_rxtx) begin
          tx_state_d = T_START;
          tx_shift_d = csr_di[7:0];
          tx_cnt_d   = 16'd0;
          tx_bit_d   = 3'd0;
          txd_d      = 1'b0;
        end
      end
      T_START: begin
        if (tx_cnt_q == DIV_M1) begin
          tx_cnt_d   = 16'd0;
          tx_state_d = T_DATA;
          txd_d      = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      T_DATA: begin
        if (tx_cnt_q == DIV_M1) begin
          tx_cnt_d = 16'd0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = T_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      T_STOP: begin
        if (tx_cnt_q == DIV_M1) begin
          tx_cnt_d   = 16'd0;
          tx_state_d = T_IDLE;
          tx_irq_d   = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  // TX registers; reset drives the line high immediately
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_state_q <= T_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'd0;
      txd_q      <= 1'b1;
      tx_irq_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
      tx_irq_q   <= tx_irq_d;
    end
  end

  // Read mux from the current address; registered below for one-cycle latency
  logic [31:0] csr_do_d, csr_do_q;
  always_comb begin
    csr_do_d = 32'd0;
    if (bank_sel) begin
      case (reg_idx)
        REG_RXTX:   csr_do_d = {24'd0, rx_data_q};
        REG_STATUS: csr_do_d = {29'd0, overrun, tx_busy, rx_full_q};
        default:    csr_do_d = 32'd0;
      endcase
    end
  end

  // Read data register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) csr_do_q <= 32'd0;
    else            csr_do_q <= csr_do_d;
  end

  logic unused_bits;
  assign unused_bits = ^{csr_a[1:0], csr_di[31:8]};

  assign csr_do   = csr_do_q;
  assign rx_irq   = rx_full_q;
  assign tx_irq   = tx_irq_q;
  assign uart_txd = txd_q;

endmodule
